// File: rtl/matmul_datapath.sv
// Pipelined N x N unsigned matrix multiplier C = A x B. It drives read addresses to
// external 1-cycle-latency A/B memories, multiply-accumulates, and writes C elements out.
module matmul_datapath #(
    parameter int DW = 8,
    parameter int N  = 8,
    parameter int AW = 6,
    parameter int CW = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [DW-1:0] i_a_data,
    input  logic [DW-1:0] i_b_data,
    output logic [AW-1:0] o_a_addr,
    output logic [AW-1:0] o_b_addr,
    output logic [AW-1:0] o_c_addr,
    output logic [CW-1:0] o_c_data,
    output logic          o_c_we,
    output logic          o_busy,
    output logic          o_done,
    output logic [10:0]   o_cycle_count,
    output logic [1:0]    o_dbg_state
);

    localparam int LN = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic [LN-1:0]   r_i, r_j, r_k;
    logic [LN-1:0]   w_i_n, w_j_n, w_k_n;
    logic            w_start;
    logic            w_last_issue;
    logic            r_v1;
    logic [LN-1:0]   r_k1;
    logic [AW-1:0]   r_e1;
    logic [2*DW-1:0] w_prod_n;
    logic [CW-1:0]   w_prod;
    logic [CW-1:0]   w_sum;
    logic [CW-1:0]   r_acc;
    logic [AW-1:0]   r_a_addr, r_b_addr, r_c_addr;
    logic [CW-1:0]   r_c_data;
    logic            r_c_we;
    logic [10:0]     r_count;

    // start is honoured only when idle or finished; a start while busy is dropped
    assign w_start      = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_issue = (&r_i) && (&r_j) && (&r_k);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if (r_c_we) w_next = S_DONE;
            S_DONE:  if (i_start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // k innermost, then j, then i
    always_comb begin
        w_k_n = r_k + 1'b1;
        w_j_n = r_j;
        w_i_n = r_i;
        if (&r_k) begin
            w_j_n = r_j + 1'b1;
            if (&r_j) w_i_n = r_i + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
        end else if (w_start) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
        end else if ((r_state == S_RUN) && !w_last_issue) begin
            r_i      <= w_i_n;
            r_j      <= w_j_n;
            r_k      <= w_k_n;
            r_a_addr <= {w_i_n, w_k_n};
            r_b_addr <= {w_k_n, w_j_n};
        end
    end

    // stage 1: tag that lines up with the memory read data one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_k1 <= '0;
            r_e1 <= '0;
        end else begin
            r_v1 <= (r_state == S_RUN);
            r_k1 <= r_k;
            r_e1 <= {r_i, r_j};
        end
    end

    assign w_prod_n = i_a_data * i_b_data;
    assign w_prod   = {{(CW-2*DW){1'b0}}, w_prod_n};
    assign w_sum    = r_acc + w_prod;

    // stage 2: accumulate; the last k writes the full sum straight to C
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_c_data <= '0;
            r_c_addr <= '0;
            r_c_we   <= 1'b0;
        end else begin
            r_c_we <= 1'b0;
            if (r_v1) begin
                r_acc <= (r_k1 == '0) ? w_prod : w_sum;
                if (&r_k1) begin
                    r_c_data <= w_sum;
                    r_c_addr <= r_e1;
                    r_c_we   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                          r_count <= '0;
        else if (w_start)                   r_count <= '0;
        else if (o_busy && (r_count != '1)) r_count <= r_count + 1'b1;
    end

    assign o_a_addr      = r_a_addr;
    assign o_b_addr      = r_b_addr;
    assign o_c_addr      = r_c_addr;
    assign o_c_data      = r_c_data;
    assign o_c_we        = r_c_we;
    assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done        = (r_state == S_DONE);
    assign o_cycle_count = r_count;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_matmul_datapath.sv
// Randomized scoreboard bench for matmul_datapath: a reference matrix product feeds an
// expected-write queue, and a monitor checks every C write plus per-cycle status/addresses.
module tb_matmul_datapath;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 6;
    localparam int CW = 19;
    localparam int N3 = N * N * N;
    localparam int QW = 32 + AW + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_a_data = '0;
    logic [DW-1:0] i_b_data = '0;
    logic [AW-1:0] o_a_addr, o_b_addr, o_c_addr;
    logic [CW-1:0] o_c_data;
    logic          o_c_we, o_busy, o_done;
    logic [10:0]   o_cycle_count;
    logic [1:0]    o_dbg_state;

    int checks = 0;
    int failures = 0;
    int tb_cyc = 0;
    int run_t0 = 0;
    bit run_active = 1'b0;

    logic [DW-1:0] mem_a [N*N];
    logic [DW-1:0] mem_b [N*N];
    logic [QW-1:0] exp_q [$];

    matmul_datapath #(.DW(DW), .N(N), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_a_data(i_a_data), .i_b_data(i_b_data),
        .o_a_addr(o_a_addr), .o_b_addr(o_b_addr), .o_c_addr(o_c_addr),
        .o_c_data(o_c_data), .o_c_we(o_c_we), .o_busy(o_busy), .o_done(o_done),
        .o_cycle_count(o_cycle_count), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc = tb_cyc + 1;

    // external synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        i_a_data <= mem_a[o_a_addr];
        i_b_data <= mem_b[o_b_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, tb_cyc);
        end
    endtask

    // monitor: sampled 1 time unit after each active edge
    always @(posedge clk) begin
        #1;
        if (o_c_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_c_we", 32'd1, 32'd0);
            end else begin
                logic [QW-1:0] ent;
                ent = exp_q.pop_front();
                chk("c_addr", 32'(o_c_addr), 32'(ent[AW+CW-1:CW]));
                chk("c_data", 32'(o_c_data), 32'(ent[CW-1:0]));
                chk("c_we_cycle", 32'(tb_cyc - run_t0), ent[QW-1:AW+CW]);
            end
        end
        if (run_active) begin
            int rel;
            rel = tb_cyc - run_t0;
            if (rel >= 1) begin
                chk("busy", 32'(o_busy), 32'(rel <= N3 + 2));
                chk("done", 32'(o_done), 32'(rel >= N3 + 3));
                chk("cycle_count", 32'(o_cycle_count), (rel - 1 > N3 + 2) ? N3 + 2 : rel - 1);
            end
            if (rel >= 1 && rel <= N3) begin
                int x, e, i, j, k;
                x = rel - 1;
                e = x / N;
                k = x % N;
                i = e / N;
                j = e % N;
                chk("a_addr", 32'(o_a_addr), i * N + k);
                chk("b_addr", 32'(o_b_addr), k * N + j);
            end
        end
    end

    // kind 0: identity x ramp, 1: all 255, 2: rows r+1 x ones, 3: random
    task automatic load_mats(input int kind);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0: begin mem_a[r*N+c] = (r == c) ? 8'd1 : 8'd0; mem_b[r*N+c] = 8'(r*N+c); end
                    1: begin mem_a[r*N+c] = 8'd255; mem_b[r*N+c] = 8'd255; end
                    2: begin mem_a[r*N+c] = 8'(r+1); mem_b[r*N+c] = 8'd1; end
                    default: begin
                        mem_a[r*N+c] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
                        mem_b[r*N+c] = 8'($urandom);
                    end
                endcase
            end
        end
    endtask

    // pulse start at this negedge; the current cycle becomes cycle 0 of the run
    task automatic run_case(input int restart_at, input int reset_at, input int hold);
        int rel;
        i_start = 1'b1;
        run_t0 = tb_cyc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int sum;
                sum = 0;
                for (int k = 0; k < N; k++) sum += int'(mem_a[i*N+k]) * int'(mem_b[k*N+j]);
                exp_q.push_back({32'(N + 2 + N * (i*N+j)), AW'(i*N+j), CW'(sum)});
            end
        end
        run_active = 1'b1;
        rel = 0;
        for (int n = 1; n < N3 + 100; n++) begin
            @(negedge clk);
            rel = tb_cyc - run_t0;
            i_start = (rel == restart_at);
            if (rel == reset_at) begin
                reset = 1'b1;
                run_active = 1'b0;
                exp_q.delete();
                @(negedge clk);
                reset = 1'b0;
                chk("abort_busy", 32'(o_busy), 0);
                chk("abort_done", 32'(o_done), 0);
                chk("abort_c_we", 32'(o_c_we), 0);
                chk("abort_count", 32'(o_cycle_count), 0);
                return;
            end
            if (o_done) break;
        end
        chk("done_seen", 32'(o_done), 1);
        chk("done_cycle", rel, N3 + 3);
        chk("final_count", 32'(o_cycle_count), N3 + 2);
        chk("writes_left", exp_q.size(), 0);
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_c_we", 32'(o_c_we), 0);
        chk("rst_count", 32'(o_cycle_count), 0);
        chk("rst_a_addr", 32'(o_a_addr), 0);
        chk("rst_b_addr", 32'(o_b_addr), 0);
        chk("rst_c_addr", 32'(o_c_addr), 0);
        chk("rst_c_data", 32'(o_c_data), 0);
        chk("rst_state", 32'(o_dbg_state), 0);
        repeat (2) @(negedge clk);

        load_mats(0); run_case(-1, -1, 3);
        load_mats(1); run_case(-1, -1, 3);
        load_mats(2); run_case(-1, -1, 3);
        load_mats(0); run_case(200, -1, 20);
        load_mats(0); run_case(-1, 100, 0);
        repeat (3) @(negedge clk);
        load_mats(0); run_case(-1, -1, 20);
        load_mats(0); run_case(-1, -1, 2);
        for (int t = 0; t < 3; t++) begin
            load_mats(3);
            run_case($urandom_range(1, N3), -1, $urandom_range(0, 5));
        end
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
